// File: rtl/spike_frame_encoder_pkg.sv
// Shared spiking-layer types and default geometry for the encoder front end.
package snn_pkg;

  localparam int unsigned SNN_NUM_SPIKES     = 16;
  localparam int unsigned SNN_PIXEL_BITS     = 8;
  localparam int unsigned SNN_LOG_TP         = 3;
  localparam int unsigned SNN_TESTING_PERIOD = 2 ** SNN_LOG_TP;
  localparam int unsigned SNN_TIME_PERIOD    = 24;
  localparam int unsigned SNN_LOG_TIME       = 5;
  localparam int unsigned SNN_THRESH         = 64;

  // {disable_l, time}: the MSB high means the input never spikes
  typedef logic [SNN_LOG_TP:0] spike_time_t;

  localparam spike_time_t SPIKE_DISABLED = {1'b1, {SNN_LOG_TP{1'b0}}};

endpackage

// File: rtl/spike_frame_encoder_if.sv
// Pixel stream into the frame encoder: valid/ready beats with a last marker and mode bit.
interface spike_frame_encoder_if
  import snn_pkg::*;
#(
  parameter int unsigned PIXEL_BITS = SNN_PIXEL_BITS
) ();

  logic                  pix_valid;
  logic                  pix_ready;
  logic [PIXEL_BITS-1:0] pix_data;
  logic                  pix_last;
  logic                  train_in;

  modport master (
    output pix_valid,
    output pix_data,
    output pix_last,
    output train_in,
    input  pix_ready
  );

  modport slave (
    input  pix_valid,
    input  pix_data,
    input  pix_last,
    input  train_in,
    output pix_ready
  );

endinterface

// File: rtl/spike_frame_encoder_latency_encoder.sv
// Latency code: brighter pixels spike earlier; pixels under threshold never spike.
module latency_encoder
  import snn_pkg::*;
#(
  parameter int unsigned PIXEL_BITS = SNN_PIXEL_BITS,
  parameter int unsigned LOG_TP     = SNN_LOG_TP,
  parameter int unsigned THRESH     = SNN_THRESH
) (
  input  logic [PIXEL_BITS-1:0] pix_i,
  output logic [LOG_TP:0]       word_o
);

  always_comb begin
    if (32'(pix_i) >= THRESH) begin
      word_o = {1'b0, ~pix_i[PIXEL_BITS-1 -: LOG_TP]};
    end else begin
      word_o = {1'b1, {LOG_TP{1'b0}}};
    end
  end

endmodule

// File: rtl/spike_frame_encoder.sv
// Frame loader with a shadow bank, and the period sequencer driving the spiking layer.
module spike_frame_encoder
  import snn_pkg::*;
#(
  parameter int unsigned NUM_SPIKES  = SNN_NUM_SPIKES,
  parameter int unsigned PIXEL_BITS  = SNN_PIXEL_BITS,
  parameter int unsigned LOG_TP      = SNN_LOG_TP,
  parameter int unsigned TIME_PERIOD = SNN_TIME_PERIOD,
  parameter int unsigned LOG_TIME    = SNN_LOG_TIME,
  parameter int unsigned THRESH      = SNN_THRESH
) (
  input  logic                              clk,
  input  logic                              rst,
  spike_frame_encoder_if.slave              pix,
  output logic [NUM_SPIKES-1:0][LOG_TP:0]   spike_times,
  output logic [LOG_TIME:0]                 time_val,
  output logic                              training,
  output logic                              frame_done,
  output logic                              len_err
);

  localparam int unsigned TESTING_PERIOD = 2 ** LOG_TP;
  localparam int unsigned IDX_W          = $clog2(NUM_SPIKES);
  localparam int unsigned TW             = LOG_TIME + 1;

  localparam logic [TW-1:0]    T_END_TRAIN = TW'(TIME_PERIOD - 1);
  localparam logic [TW-1:0]    T_END_TEST  = TW'(TESTING_PERIOD - 1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_SPIKES - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [LOG_TP:0]                 DIS_WORD = {1'b1, {LOG_TP{1'b0}}};
  localparam logic [NUM_SPIKES-1:0][LOG_TP:0] ALL_DIS  = {NUM_SPIKES{DIS_WORD}};

  logic [NUM_SPIKES-1:0][LOG_TP:0] shadow_q, shadow_d;
  logic [NUM_SPIKES-1:0][LOG_TP:0] active_q, active_d;
  logic [IDX_W-1:0]                fill_q, fill_d;
  logic                            shadow_full_q, shadow_full_d;
  logic                            shadow_train_q, shadow_train_d;
  logic [0:0]                      state_q, state_d;
  logic [TW-1:0]                   time_q, time_d;
  logic                            training_q, training_d;
  logic                            frame_done_q, frame_done_d;
  logic                            len_err_q, len_err_d;

  logic [LOG_TP:0] enc_word;
  logic            accept;
  logic            at_end;
  logic            swap;
  logic [TW-1:0]   end_t;

  latency_encoder #(
    .PIXEL_BITS (PIXEL_BITS),
    .LOG_TP     (LOG_TP),
    .THRESH     (THRESH)
  ) u_enc (
    .pix_i  (pix.pix_data),
    .word_o (enc_word)
  );

  assign pix.pix_ready = !shadow_full_q;
  assign end_t         = training_q ? T_END_TRAIN : T_END_TEST;
  assign accept        = pix.pix_valid && !shadow_full_q;
  assign at_end        = (state_q == ST_RUN) && (time_q == end_t);
  assign swap          = shadow_full_q && ((state_q == ST_IDLE) || at_end);

  always_comb begin
    shadow_d       = shadow_q;
    active_d       = active_q;
    fill_d         = fill_q;
    shadow_full_d  = shadow_full_q;
    shadow_train_d = shadow_train_q;
    state_d        = state_q;
    time_d         = time_q;
    training_d     = training_q;
    frame_done_d   = 1'b0;
    len_err_d      = 1'b0;

    // Accept and swap never coincide: a swap needs shadow_full, which blocks accept.
    if (accept) begin
      shadow_d[fill_q] = enc_word;
      if (fill_q == '0) begin
        shadow_train_d = pix.train_in;
      end
      if (pix.pix_last && (fill_q == LAST_IDX)) begin
        shadow_full_d = 1'b1;
        fill_d        = '0;
      end else if (pix.pix_last || (fill_q == LAST_IDX)) begin
        len_err_d = 1'b1;
        fill_d    = '0;
      end else begin
        fill_d = fill_q + 1'b1;
      end
    end

    if (state_q == ST_RUN) begin
      time_d = time_q + 1'b1;
      if (at_end) begin
        frame_done_d = 1'b1;
        if (!swap) begin
          state_d    = ST_IDLE;
          active_d   = ALL_DIS;
          time_d     = T_END_TRAIN;
          training_d = 1'b0;
        end
      end
    end

    if (swap) begin
      active_d      = shadow_q;
      training_d    = shadow_train_q;
      shadow_full_d = 1'b0;
      time_d        = '0;
      state_d       = ST_RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q       <= ALL_DIS;
      active_q       <= ALL_DIS;
      fill_q         <= '0;
      shadow_full_q  <= 1'b0;
      shadow_train_q <= 1'b0;
      state_q        <= ST_IDLE;
      time_q         <= T_END_TRAIN;
      training_q     <= 1'b0;
      frame_done_q   <= 1'b0;
      len_err_q      <= 1'b0;
    end else begin
      shadow_q       <= shadow_d;
      active_q       <= active_d;
      fill_q         <= fill_d;
      shadow_full_q  <= shadow_full_d;
      shadow_train_q <= shadow_train_d;
      state_q        <= state_d;
      time_q         <= time_d;
      training_q     <= training_d;
      frame_done_q   <= frame_done_d;
      len_err_q      <= len_err_d;
    end
  end

  assign spike_times = active_q;
  assign time_val    = time_q;
  assign training    = training_q;
  assign frame_done  = frame_done_q;
  assign len_err     = len_err_q;

endmodule
